// File: rtl/spi_device_fifo.sv
// SPI device shifter (WIDTH/CPOL/CPHA parameterised) with a TX FIFO and an RX valid/ready holding register.
// Pin-to-action latency SYNC_STAGES+1 clk; tx_ready drops when the FIFO is full, an unaccepted rx word drops the next one.
module spi_device_fifo #(
   parameter int WIDTH       = 8,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int TX_DEPTH    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              spi_sck,
   input  logic                              spi_cs,
   input  logic                              spi_sdi,
   output logic                              spi_sdo,
   output logic [WIDTH-1:0]                  rx_data,
   output logic                              rx_valid,
   input  logic                              rx_ready,
   input  logic [WIDTH-1:0]                  tx_data,
   input  logic                              tx_valid,
   output logic                              tx_ready,
   output logic [$clog2(TX_DEPTH+1)-1:0]     tx_level,
   output logic                              busy,
   output logic                              tx_underrun,
   output logic                              rx_overrun,
   input  logic                              clear_flags
);
   localparam int LW = $clog2(TX_DEPTH + 1);
   localparam int PW = $clog2(TX_DEPTH);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic            CPOL_B   = (CPOL != 0);
   localparam logic [CW-1:0]   CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
   localparam logic [LW-1:0]   LVL_FULL = LW'(TX_DEPTH);

   typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

   logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, sdi_sync_q;
   logic                   sck_hist_q, cs_hist_q;
   logic                   sck_s, sck_p, lead, trail, cs_s, cs_fall, sdi_s;

   state_t                 state_q;
   logic [CW-1:0]          cnt_q;
   logic [WIDTH-1:0]       tx_shift_q, rx_shift_q, rx_data_q;
   logic                   done_q, rx_valid_q, tx_underrun_q, rx_overrun_q;
   logic                   load, sample, shift, complete;

   logic [WIDTH-1:0]       mem_q [TX_DEPTH];
   logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]          level_q, level_d;
   logic                   push, pop, und_set, ovr_set;

   // Synchronisers; the sck chain resets to the idle level so no edge is seen out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sck_sync_q <= {SYNC_STAGES{CPOL_B}};
         cs_sync_q  <= '0;
         sdi_sync_q <= '0;
         sck_hist_q <= CPOL_B;
         cs_hist_q  <= 1'b0;
      end else begin
         sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
         cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
         sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
         sck_hist_q <= sck_sync_q[SYNC_STAGES-1];
         cs_hist_q  <= cs_sync_q[SYNC_STAGES-1];
      end
   end

   assign sck_s   = sck_sync_q[SYNC_STAGES-1] ^ CPOL_B;
   assign sck_p   = sck_hist_q ^ CPOL_B;
   assign lead    = sck_s & ~sck_p;
   assign trail   = ~sck_s & sck_p;
   assign cs_s    = cs_sync_q[SYNC_STAGES-1];
   assign cs_fall = ~cs_s & cs_hist_q;
   assign sdi_s   = sdi_sync_q[SYNC_STAGES-1];

   always_comb begin
      load     = 1'b0;
      sample   = 1'b0;
      shift    = 1'b0;
      complete = 1'b0;
      if (state_q == IDLE && cs_fall) begin
         load = 1'b1;
      end else if (state_q == ACTIVE && !cs_s) begin
         if (CPHA == 0) begin
            if (lead) begin
               sample = 1'b1;
            end else if (trail) begin
               if (cnt_q == CNT_FULL) begin
                  complete = 1'b1;
                  load     = 1'b1;
               end else begin
                  shift = 1'b1;
               end
            end
         end else begin
            if (lead && cnt_q != '0) begin
               shift = 1'b1;
            end else if (trail) begin
               sample = 1'b1;
               if (cnt_q == CNT_LAST) begin
                  complete = 1'b1;
                  load     = 1'b1;
               end
            end
         end
      end
   end

   assign tx_ready = (level_q != LVL_FULL);
   assign push     = tx_valid && tx_ready;
   assign pop      = load && (level_q != '0);
   assign und_set  = load && (level_q == '0);
   assign ovr_set  = done_q && rx_valid_q && !rx_ready;

   always_comb begin
      level_d = level_q;
      if (push && !pop) level_d = level_q + 1'b1;
      else if (!push && pop) level_d = level_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= WAIT_IDLE;
         cnt_q      <= '0;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            WAIT_IDLE: if (cs_s) state_q <= IDLE;
            IDLE: begin
               if (cs_fall) begin
                  state_q <= ACTIVE;
                  cnt_q   <= '0;
               end
            end
            ACTIVE: begin
               if (cs_s) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (complete) begin
                  cnt_q <= '0;
               end else if (sample) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= WAIT_IDLE;
         endcase
         if (load) tx_shift_q <= pop ? mem_q[rd_ptr_q] : '0;
         else if (shift) tx_shift_q <= {tx_shift_q[WIDTH-2:0], 1'b0};
         if (sample) rx_shift_q <= {rx_shift_q[WIDTH-2:0], sdi_s};
         done_q <= complete;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         tx_underrun_q <= 1'b0;
         rx_overrun_q  <= 1'b0;
      end else begin
         if (done_q) begin
            if (!ovr_set) begin
               rx_data_q  <= rx_shift_q;
               rx_valid_q <= 1'b1;
            end
         end else if (rx_ready) begin
            rx_valid_q <= 1'b0;
         end
         tx_underrun_q <= und_set | (tx_underrun_q & ~clear_flags);
         rx_overrun_q  <= ovr_set | (rx_overrun_q & ~clear_flags);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= tx_data;
   end

   assign spi_sdo     = tx_shift_q[WIDTH-1];
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_level    = level_q;
   assign busy        = (state_q == ACTIVE);
   assign tx_underrun = tx_underrun_q;
   assign rx_overrun  = rx_overrun_q;
endmodule
